// File: rtl/button_conditioner.sv
// button_conditioner -- push-button front end for the reaction timer.
//
// Each raw button goes through a 2-FF synchroniser and a debounce FSM
// (RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING). The block produces a
// clean level and one-cycle press/release pulses per button, plus an
// optional one-cycle long-press pulse.
//
// Optional feature macro: BUTTON_LONG_PRESS_EN
//   defined     -> hold counters and btn_long logic are built
//   not defined -> btn_long is tied to 0 and LONG_PRESS_CYCLES is ignored
//
// Ports (button_conditioner):
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   enable       in   0 suppresses all pulse outputs; levels keep tracking
//   btn_raw      in   [N_BUTTONS] raw asynchronous button inputs, active-high
//   btn_level    out  [N_BUTTONS] debounced level
//   btn_press    out  [N_BUTTONS] one-cycle pulse on accepted press
//   btn_release  out  [N_BUTTONS] one-cycle pulse on accepted release
//   btn_long     out  [N_BUTTONS] one-cycle pulse once per long press
//   any_press    out  OR of btn_press

// One button channel: synchroniser, debounce FSM, optional hold counter.
module button_channel #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 200_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_nxt,  // next-cycle value of press, for the shared OR
    output logic rel,
    output logic long_p
);
    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
        $error("button_channel: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
    end

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } state_t;

    logic          sync1_q, sync_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync_q) begin
                    state_d = PRESS_PENDING;
                    cnt_d   = '0;
                end
            end
            PRESS_PENDING: begin
                if (!sync_q) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = enable;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync_q) begin
                    state_d = RELEASE_PENDING;
                    cnt_d   = '0;
                end
            end
            RELEASE_PENDING: begin
                if (sync_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    level_d = 1'b0;
                    rel_d   = enable;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    assign level     = level_q;
    assign press     = press_q;
    assign press_nxt = press_d;
    assign rel       = rel_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_q, long_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Saturating at LONG_PRESS_CYCLES guarantees hold_q passes HOLD_LAST
    // only once per press, so btn_long fires at most once.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q == PRESS_PENDING && state_d == PRESSED) begin
            hold_d = '0;
        end else if (state_q == PRESSED || state_q == RELEASE_PENDING) begin
            if (hold_q == HOLD_LAST) long_d = enable;
            if (hold_q != HOLD_MAX)  hold_d = hold_q + HW'(1);
        end
    end

    assign long_p = long_q;
`else
    assign long_p = 1'b0;
`endif
endmodule

module button_conditioner #(
    parameter int N_BUTTONS         = 3,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 200_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release,
    output logic [N_BUTTONS-1:0] btn_long,
    output logic                 any_press
);
    logic [N_BUTTONS-1:0] press_nxt;
    logic                 any_press_q, any_press_d;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .raw      (btn_raw[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i]),
            .press_nxt(press_nxt[i]),
            .rel      (btn_release[i]),
            .long_p   (btn_long[i])
        );
    end

    // Registered from the channels' next-cycle press so it lines up with btn_press.
    always_comb any_press_d = |press_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_press_q <= 1'b0;
        else       any_press_q <= any_press_d;
    end

    assign any_press = any_press_q;
endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
    localparam int NB = 3;
    localparam int D  = 4;
    localparam int L  = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_long;
    logic          any_press;

    button_conditioner #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
        .clk(clk), .reset(reset), .enable(enable), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_long(btn_long), .any_press(any_press)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Edge index, incremented at every rising edge.
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Behavioural model: the FSM sees raw delayed by two edges. A new level is
    // accepted once D+1 consecutive samples disagree with the current level.
    // A long pulse occurs L edges after a press while the level was still high.
    logic [NB-1:0] h0, h1;
    logic [NB-1:0] m_level, m_press, m_rel, m_long;
    logic          m_any;
    int            run  [NB];
    int            age  [NB];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            h0 = '0; h1 = '0;
            m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_any = 1'b0;
            for (int i = 0; i < NB; i++) begin run[i] = 0; age[i] = 0; end
        end else begin
            logic [NB-1:0] samp, old_level;
            samp = h1; h1 = h0; h0 = btn_raw;
            old_level = m_level;
            m_press = '0; m_rel = '0; m_long = '0;
            for (int i = 0; i < NB; i++) begin
                if (old_level[i]) begin
                    age[i]++;
`ifdef BUTTON_LONG_PRESS_EN
                    if (age[i] == L) m_long[i] = enable;
`endif
                end
                if (samp[i] != old_level[i]) run[i]++;
                else run[i] = 0;
                if (run[i] == D + 1) begin
                    run[i] = 0;
                    m_level[i] = samp[i];
                    if (samp[i]) begin m_press[i] = enable; age[i] = 0; end
                    else m_rel[i] = enable;
                end
            end
            m_any = |m_press;
        end
    end

    // Per-cycle comparison plus pulse bookkeeping for the literal checks.
    int n_press [NB];
    int n_rel   [NB];
    int n_long  [NB];
    int t_press [NB];
    int t_rel   [NB];
    int t_long  [NB];
    int n_any = 0;
    initial for (int i = 0; i < NB; i++) begin
        n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
        t_press[i] = -1; t_rel[i] = -1; t_long[i] = -1;
    end

    always @(negedge clk) begin
        chk("model_cycle",
            {btn_level, btn_press, btn_release, btn_long, any_press},
            {m_level, m_press, m_rel, m_long, m_any});
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i])   begin n_press[i]++; t_press[i] = edge_n; end
            if (btn_release[i]) begin n_rel[i]++;   t_rel[i]   = edge_n; end
            if (btn_long[i])    begin n_long[i]++;  t_long[i]  = edge_n; end
        end
        if (any_press) n_any++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int t0, tf, p0, r0, l0, p1, r1, p2, r2, a0;
`ifdef BUTTON_LONG_PRESS_EN
    localparam int LONG_ON = 1;
`else
    localparam int LONG_ON = 0;
`endif

    initial begin
        step(3);
        chk("reset_outputs", {btn_level, btn_press, btn_release, btn_long, any_press}, 0);
        reset = 1'b0;
        step(3);

        // Clean press on channel 0, held 20 cycles.
        p0 = n_press[0]; l0 = n_long[0]; a0 = n_any;
        t0 = edge_n + 1; btn_raw[0] = 1'b1;
        step(20);
        chk("clean_press_count", n_press[0] - p0, 1);
        chk("clean_press_time", t_press[0] - t0, 6);
        chk("clean_any_count", n_any - a0, 1);
        chk("clean_level", btn_level[0], 1);
        chk("clean_long_count", n_long[0] - l0, LONG_ON);
        if (LONG_ON == 1) chk("clean_long_time", t_long[0] - t0, 16);
        r0 = n_rel[0];
        tf = edge_n + 1; btn_raw[0] = 1'b0;
        step(10);
        chk("clean_release_time", t_rel[0] - tf, 6);
        chk("clean_release_count", n_rel[0] - r0, 1);

        // Bounce on channel 1, then a stable hold.
        p1 = n_press[1]; r1 = n_rel[1];
        btn_raw[1] = 1'b1; step(2);
        btn_raw[1] = 1'b0; step(2);
        btn_raw[1] = 1'b1; step(2);
        btn_raw[1] = 1'b0; step(2);
        t0 = edge_n + 1; btn_raw[1] = 1'b1;
        step(12);
        chk("bounce_press_count", n_press[1] - p1, 1);
        chk("bounce_press_time", t_press[1] - t0, 6);
        chk("bounce_no_release", n_rel[1] - r1, 0);
        btn_raw[1] = 1'b0;
        step(12);

        // Short press on channel 0: no long pulse.
        p0 = n_press[0]; r0 = n_rel[0]; l0 = n_long[0];
        btn_raw[0] = 1'b1; step(8);
        tf = edge_n + 1; btn_raw[0] = 1'b0;
        step(14);
        chk("short_press_count", n_press[0] - p0, 1);
        chk("short_release_count", n_rel[0] - r0, 1);
        chk("short_release_time", t_rel[0] - tf, 6);
        chk("short_no_long", n_long[0] - l0, 0);

        // Simultaneous press on all channels.
        a0 = n_any;
        t0 = edge_n + 1; btn_raw = 3'b111;
        step(8);
        chk("simul_t0", t_press[0] - t0, 6);
        chk("simul_t1", t_press[1] - t0, 6);
        chk("simul_t2", t_press[2] - t0, 6);
        chk("simul_any_count", n_any - a0, 1);
        btn_raw = 3'b000;
        step(12);

        // Enable gating on channel 2.
        p2 = n_press[2]; r2 = n_rel[2];
        enable = 1'b0;
        btn_raw[2] = 1'b1; step(8);
        chk("gate_level_high", btn_level[2], 1);
        btn_raw[2] = 1'b0; step(8);
        chk("gate_level_low", btn_level[2], 0);
        enable = 1'b1; step(5);
        chk("gate_no_press", n_press[2] - p2, 0);
        chk("gate_no_release", n_rel[2] - r2, 0);

        // Reset while channel 0 is pending and the button stays held.
        p0 = n_press[0];
        btn_raw[0] = 1'b1; step(3);
        reset = 1'b1; #1;
        chk("reset_mid_outputs", {btn_level, btn_press, btn_release, btn_long, any_press}, 0);
        step(2);
        t0 = edge_n + 1; reset = 1'b0;
        step(10);
        chk("reset_mid_press_count", n_press[0] - p0, 1);
        chk("reset_mid_press_time", t_press[0] - t0, 6);
        btn_raw[0] = 1'b0;
        step(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
